// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the CP0 interrupt controller: FSM encoding,
// cause-code defaults and CP0 register indices.
package int_ctrl_pkg;

  localparam int unsigned NUM_SRC_DEF = 8;
  localparam int unsigned CAUSE_W_DEF = 5;
  localparam logic [4:0] CAUSE_BASE_DEF = 5'd8;

  // CP0 register indices touched by the controller's write side
  localparam logic [4:0] CP0_REG_ENABLE = 5'd11;
  localparam logic [4:0] CP0_REG_BASE   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2,
    ST_EXIT    = 2'd3
  } state_t;

  // Width of a source index; at least one bit even for a single source
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest set pending bit wins.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF
) (
  input  logic [NUM_SRC-1:0]            pending,
  output logic [sel_width(NUM_SRC)-1:0] sel,
  output logic                          valid
);

  localparam int unsigned SEL_W = sel_width(NUM_SRC);

  // Scan from the top down so the lowest set index is the final assignment
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      if (pending[k]) begin
        sel   = SEL_W'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller feeding the CP0 write port: edge capture, priority
// selection, pipeline handshake and EPC/Cause/enable write strobes.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned          NUM_SRC    = NUM_SRC_DEF,
  parameter int unsigned          CAUSE_W    = CAUSE_W_DEF,
  parameter logic [CAUSE_W-1:0]   CAUSE_BASE = CAUSE_W'(CAUSE_BASE_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  irq_i,
  input  logic                int_en_i,
  input  logic [31:0]         pc_i,
  input  logic                take_i,
  input  logic                eret_i,
  output logic                int_req_o,
  output logic                int_taken_o,
  output logic                write_epc_o,
  output logic                write_cause_o,
  output logic                write_int_o,
  output logic                int_en_wr_o,
  output logic [31:0]         epc_o,
  output logic [CAUSE_W-1:0]  cause_o,
  output logic [NUM_SRC-1:0]  pending_o
);

  localparam int unsigned SEL_W = sel_width(NUM_SRC);

  state_t             state;
  state_t             state_next;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] clr;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic               take;

  int_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .pending (pending),
    .sel     (sel),
    .valid   (sel_valid)
  );

  // Next state, request and pending update; a new edge beats a same-cycle clear
  always_comb begin
    state_next = state;
    take       = 1'b0;
    clr        = '0;
    int_req_o  = (state == ST_IDLE) && sel_valid && int_en_i;
    unique case (state)
      ST_IDLE: begin
        if (int_req_o && take_i) begin
          take       = 1'b1;
          clr[sel]   = 1'b1;
          state_next = ST_ENTER;
        end
      end
      ST_ENTER:   state_next = ST_SERVICE;
      ST_SERVICE: if (eret_i) state_next = ST_EXIT;
      ST_EXIT:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    pending_next = (pending & ~clr) | (irq_i & ~irq_prev);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Edge detector history and pending latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq_i;
      pending  <= pending_next;
    end
  end

  // EPC/Cause capture on the take edge; held until the next entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_o   <= '0;
      cause_o <= '0;
    end else if (take) begin
      epc_o   <= pc_i;
      cause_o <= CAUSE_BASE + CAUSE_W'(sel);
    end
  end

  // Write strobes registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_taken_o   <= 1'b0;
      write_epc_o   <= 1'b0;
      write_cause_o <= 1'b0;
      write_int_o   <= 1'b0;
      int_en_wr_o   <= 1'b0;
    end else begin
      int_taken_o   <= (state_next == ST_ENTER);
      write_epc_o   <= (state_next == ST_ENTER);
      write_cause_o <= (state_next == ST_ENTER);
      write_int_o   <= (state_next == ST_ENTER) || (state_next == ST_EXIT);
      int_en_wr_o   <= (state_next == ST_EXIT);
    end
  end

  assign pending_o = pending;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with a transaction-level reference model.
module tb_int_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq_i;
  logic        int_en_i;
  logic [31:0] pc_i;
  logic        take_i;
  logic        eret_i;
  logic        int_req_o;
  logic        int_taken_o;
  logic        write_epc_o;
  logic        write_cause_o;
  logic        write_int_o;
  logic        int_en_wr_o;
  logic [31:0] epc_o;
  logic [4:0]  cause_o;
  logic [7:0]  pending_o;

  int vectors = 0;
  int errors  = 0;

  int_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_i         (irq_i),
    .int_en_i      (int_en_i),
    .pc_i          (pc_i),
    .take_i        (take_i),
    .eret_i        (eret_i),
    .int_req_o     (int_req_o),
    .int_taken_o   (int_taken_o),
    .write_epc_o   (write_epc_o),
    .write_cause_o (write_cause_o),
    .write_int_o   (write_int_o),
    .int_en_wr_o   (int_en_wr_o),
    .epc_o         (epc_o),
    .cause_o       (cause_o),
    .pending_o     (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: interrupt handler occupancy tracked as flags
  bit [7:0]  m_pend;
  bit [7:0]  m_prev;
  bit        m_in_isr;   // from the taken interrupt until ERET is honoured
  bit        m_enter;    // first cycle of a taken interrupt
  bit        m_exit;     // cycle after ERET is honoured
  bit [31:0] m_epc;
  bit [4:0]  m_cause;

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit model_req();
    return !m_in_isr && !m_exit && (m_pend != 0) && int_en_i;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit go_in, go_out;
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_in_isr = 0; m_enter = 0; m_exit = 0;
      m_epc = '0; m_cause = '0;
    end else begin
      go_in  = model_req() && take_i;
      go_out = m_in_isr && !m_enter && eret_i;
      if (go_in) begin
        m_epc   = pc_i;
        m_cause = 5'(8 + lowest(m_pend));
        m_pend[lowest(m_pend)] = 1'b0;
      end
      m_pend   = m_pend | (irq_i & ~m_prev);
      m_prev   = irq_i;
      m_in_isr = (m_in_isr && !go_out) || go_in;
      m_enter  = go_in;
      m_exit   = go_out;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("req",       32'(int_req_o),     32'(model_req()));
    chk("taken",     32'(int_taken_o),   32'(m_enter));
    chk("wr_epc",    32'(write_epc_o),   32'(m_enter));
    chk("wr_cause",  32'(write_cause_o), 32'(m_enter));
    chk("wr_int",    32'(write_int_o),   32'(m_enter || m_exit));
    chk("en_wr",     32'(int_en_wr_o),   32'(m_exit));
    chk("epc",       epc_o,              m_epc);
    chk("cause",     32'(cause_o),       32'(m_cause));
    chk("pending",   32'(pending_o),     32'(m_pend));
  end

  // Advance to just after the next falling edge; inputs set afterwards hit the next rising edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_req"},   32'(int_req_o),   0);
    chk({tag, "_taken"}, 32'(int_taken_o), 0);
    chk({tag, "_wint"},  32'(write_int_o), 0);
    chk({tag, "_epc"},   epc_o,            0);
    chk({tag, "_cause"}, 32'(cause_o),     0);
    chk({tag, "_pend"},  32'(pending_o),   0);
  endtask

  // Service an already-entered interrupt through ERET back to IDLE
  task automatic finish_isr();
    take_i = 1'b0;
    tick();
    eret_i = 1'b1;
    tick();
    chk("exit_wint", 32'(write_int_o), 1);
    chk("exit_enwr", 32'(int_en_wr_o), 1);
    eret_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; irq_i = '0; int_en_i = 1'b1; pc_i = '0; take_i = 1'b0; eret_i = 1'b0;
    tick(2);
    all_zero("rst");
    rst_n = 1'b1;
    tick(3);
    chk("idle_req", 32'(int_req_o), 0);

    // Single source 3 taken immediately
    irq_i = 8'h08; pc_i = 32'h0040_0020; take_i = 1'b1;
    tick();
    chk("s2_req", 32'(int_req_o), 1);
    irq_i = '0;
    tick();
    chk("s2_taken", 32'(int_taken_o), 1);
    chk("s2_wepc",  32'(write_epc_o), 1);
    chk("s2_wcause",32'(write_cause_o), 1);
    chk("s2_wint",  32'(write_int_o), 1);
    chk("s2_enwr",  32'(int_en_wr_o), 0);
    chk("s2_epc",   epc_o, 32'h0040_0020);
    chk("s2_cause", 32'(cause_o), 11);
    finish_isr();

    // Sources 5 and 1 together: 1 first, then 5
    irq_i = 8'h22; pc_i = 32'h0000_1000;
    tick();
    chk("s3_pend", 32'(pending_o), 32'h22);
    irq_i = '0; take_i = 1'b1;
    tick();
    chk("s3_cause1", 32'(cause_o), 9);
    finish_isr();
    chk("s3_req2", 32'(int_req_o), 1);
    pc_i = 32'h0000_2004; take_i = 1'b1;
    tick();
    chk("s3_cause2", 32'(cause_o), 13);
    chk("s3_epc2",   epc_o, 32'h0000_2004);
    finish_isr();

    // Disabled: request held back, pending kept
    int_en_i = 1'b0; irq_i = 8'h01;
    tick();
    chk("s4_req_off", 32'(int_req_o), 0);
    chk("s4_pend",    32'(pending_o), 1);
    irq_i = '0;
    tick();
    int_en_i = 1'b1;
    #1;
    chk("s4_req_on", 32'(int_req_o), 1);
    tick(3);
    chk("s4_req_hold", 32'(int_req_o), 1);
    take_i = 1'b1; pc_i = 32'h0000_3000;
    tick();
    chk("s4_cause", 32'(cause_o), 8);
    finish_isr();

    // ERET in IDLE ignored; reset during SERVICE
    eret_i = 1'b1;
    tick();
    chk("s5_eret_wint", 32'(write_int_o), 0);
    chk("s5_eret_enwr", 32'(int_en_wr_o), 0);
    eret_i = 1'b0; irq_i = 8'h04;
    tick();
    irq_i = '0; take_i = 1'b1; pc_i = 32'h0000_4000;
    tick();
    take_i = 1'b0; irq_i = 8'h10;
    tick();
    irq_i = '0;
    chk("s5_pend_pre", 32'(pending_o), 32'h10);
    rst_n = 1'b0;
    #1;
    all_zero("s5_rst");
    tick();
    rst_n = 1'b1;
    tick(2);

    // Source 2 re-fires on the very edge that takes it
    irq_i = 8'h04;
    tick();
    irq_i = '0;
    tick();
    take_i = 1'b1; irq_i = 8'h04; pc_i = 32'h0000_5000;
    tick();
    chk("s6_cause", 32'(cause_o), 10);
    chk("s6_pend",  32'(pending_o), 32'h04);
    irq_i = '0;
    finish_isr();
    chk("s6_req", 32'(int_req_o), 1);
    take_i = 1'b1;
    tick();
    chk("s6_cause2", 32'(cause_o), 10);
    chk("s6_pend2",  32'(pending_o), 0);
    finish_isr();
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
